// File: rtl/corelet_acc.sv
// corelet_acc: L0 -> MAC array -> OFIFO datapath with an on-corelet SFU that drains the
// OFIFO into a saturating multi-pass psum buffer and streams finished tiles out with optional ReLU.

module corelet_fifo #(
  parameter int width = 32,
  parameter int depth = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [width-1:0] in_i,
  output logic [width-1:0] out_o,
  output logic             full_o,
  output logic             valid_o
);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push;
  logic             pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = (wr_ptr_q != rd_ptr_q);
  assign push    = wr_i && !full_o;
  assign pop     = rd_i && valid_o;
  assign out_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= in_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
endmodule

module l0 #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [row*bw-1:0] in_i,
  output logic [row*bw-1:0] out_o,
  output logic              full_o,
  output logic              valid_o
);
  corelet_fifo #(.width(row*bw), .depth(depth)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .wr_i    (wr_i),
    .rd_i    (rd_i),
    .in_i    (in_i),
    .out_o   (out_o),
    .full_o  (full_o),
    .valid_o (valid_o)
  );
endmodule

module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_i,
  input  logic                   rd_i,
  input  logic [col*psum_bw-1:0] in_i,
  output logic [col*psum_bw-1:0] out_o,
  output logic                   full_o,
  output logic                   valid_o
);
  corelet_fifo #(.width(col*psum_bw), .depth(depth)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .wr_i    (wr_i),
    .rd_i    (rd_i),
    .in_i    (in_i),
    .out_o   (out_o),
    .full_o  (full_o),
    .valid_o (valid_o)
  );
endmodule

module mac_array #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [1:0]             inst_w_i,
  input  logic [row*bw-1:0]      in_w_i,
  input  logic [col*psum_bw-1:0] in_n_i,
  output logic [col*psum_bw-1:0] out_s_o,
  output logic                   valid_o
);
  localparam int CW = (col > 1) ? $clog2(col) : 1;

  logic [row*bw-1:0]          w_q [col];
  logic [CW-1:0]              load_col_q;
  logic [col*psum_bw-1:0]     psum_d;
  logic [col*psum_bw-1:0]     psum_q;
  logic                       valid_q;
  logic signed [psum_bw-1:0]  act_ext;
  logic signed [psum_bw-1:0]  wgt_ext;
  logic signed [psum_bw-1:0]  lane_sum;

  // Activations are unsigned, weights signed; column c holds one weight per row.
  always_comb begin
    psum_d   = '0;
    act_ext  = '0;
    wgt_ext  = '0;
    lane_sum = '0;
    for (int unsigned c = 0; c < col; c++) begin
      lane_sum = $signed(in_n_i[c*psum_bw +: psum_bw]);
      for (int unsigned r = 0; r < row; r++) begin
        act_ext  = $signed(psum_bw'(in_w_i[r*bw +: bw]));
        wgt_ext  = psum_bw'($signed(w_q[c][r*bw +: bw]));
        lane_sum = lane_sum + act_ext * wgt_ext;
      end
      psum_d[c*psum_bw +: psum_bw] = lane_sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned c = 0; c < col; c++) begin
        w_q[c] <= '0;
      end
      load_col_q <= '0;
      psum_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (inst_w_i[0]) begin
        w_q[load_col_q] <= in_w_i;
        load_col_q      <= (load_col_q == CW'(col - 1)) ? '0 : load_col_q + 1'b1;
      end
      valid_q <= inst_w_i[1];
      if (inst_w_i[1]) begin
        psum_q <= psum_d;
      end
    end
  end

  assign out_s_o = psum_q;
  assign valid_o = valid_q;
endmodule

module corelet_acc #(
  parameter int row       = 8,
  parameter int col       = 8,
  parameter int bw        = 4,
  parameter int psum_bw   = 16,
  parameter int acc_depth = 16,
  parameter int inst_bw   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [inst_bw-1:0]     inst,
  input  logic [row*bw-1:0]      l0_in,
  output logic                   l0_o_full,
  output logic                   ofifo_o_full,
  output logic [col*psum_bw-1:0] sfu_out,
  output logic                   sfu_o_valid,
  output logic                   sfu_o_last,
  output logic                   acc_wrap,
  output logic                   busy
);
  localparam int AW = (acc_depth > 1) ? $clog2(acc_depth) : 1;
  localparam int VW = col * psum_bw;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_e;

  logic          acc_en;
  logic          acc_clr;
  logic          relu_en;
  logic          rd_start;
  logic [row*bw-1:0] l0_out;
  logic          l0_valid;
  logic [VW-1:0] mac_out;
  logic          mac_valid;
  logic [VW-1:0] ofifo_out;
  logic          ofifo_valid;
  logic          ofifo_rd;
  logic [VW-1:0] acc_sum_d;
  logic          unused_ok;

  state_e        state_q;
  logic [VW-1:0] acc_mem_q [acc_depth];
  logic [AW-1:0] acc_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic          relu_q;
  logic [VW-1:0] sfu_out_q;
  logic          sfu_valid_q;
  logic          sfu_last_q;
  logic          acc_wrap_q;

  assign acc_en    = inst[4];
  assign acc_clr   = inst[5];
  assign relu_en   = inst[6];
  assign rd_start  = inst[7];
  assign unused_ok = ^{inst[inst_bw-1:8], l0_valid};

  l0 #(.row(row), .bw(bw), .depth(16)) u_l0 (
    .clk_i   (clk),
    .reset_i (reset),
    .wr_i    (inst[2]),
    .rd_i    (inst[3]),
    .in_i    (l0_in),
    .out_o   (l0_out),
    .full_o  (l0_o_full),
    .valid_o (l0_valid)
  );

  mac_array #(.row(row), .col(col), .bw(bw), .psum_bw(psum_bw)) u_mac (
    .clk_i    (clk),
    .reset_i  (reset),
    .inst_w_i (inst[1:0]),
    .in_w_i   (l0_out),
    .in_n_i   ('0),
    .out_s_o  (mac_out),
    .valid_o  (mac_valid)
  );

  ofifo #(.col(col), .psum_bw(psum_bw), .depth(16)) u_ofifo (
    .clk_i   (clk),
    .reset_i (reset),
    .wr_i    (mac_valid),
    .rd_i    (ofifo_rd),
    .in_i    (mac_out),
    .out_o   (ofifo_out),
    .full_o  (ofifo_o_full),
    .valid_o (ofifo_valid)
  );

  function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0]      r;
    logic [psum_bw:0]   s;
    r = '0;
    for (int unsigned c = 0; c < col; c++) begin
      s = {a[c*psum_bw + psum_bw - 1], a[c*psum_bw +: psum_bw]}
        + {b[c*psum_bw + psum_bw - 1], b[c*psum_bw +: psum_bw]};
      if (s[psum_bw] != s[psum_bw-1]) begin
        r[c*psum_bw +: psum_bw] = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                             : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
        r[c*psum_bw +: psum_bw] = s[psum_bw-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] relu(input logic [VW-1:0] v, input logic en);
    logic [VW-1:0] r;
    r = v;
    for (int unsigned c = 0; c < col; c++) begin
      if (en && v[c*psum_bw + psum_bw - 1]) begin
        r[c*psum_bw +: psum_bw] = '0;
      end
    end
    return r;
  endfunction

  // Pop is combinational so the FWFT head is consumed on the same edge it is accumulated.
  assign ofifo_rd  = (state_q == ACC) && acc_en && ofifo_valid;
  assign acc_sum_d = sat_add(acc_mem_q[acc_ptr_q], ofifo_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int unsigned e = 0; e < acc_depth; e++) begin
        acc_mem_q[e] <= '0;
      end
      acc_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      relu_q      <= 1'b0;
      sfu_out_q   <= '0;
      sfu_valid_q <= 1'b0;
      sfu_last_q  <= 1'b0;
      acc_wrap_q  <= 1'b0;
    end else begin
      sfu_valid_q <= 1'b0;
      sfu_last_q  <= 1'b0;
      acc_wrap_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc_clr) begin
            for (int unsigned e = 0; e < acc_depth; e++) begin
              acc_mem_q[e] <= '0;
            end
            acc_ptr_q <= '0;
          end else if (rd_start) begin
            // Entry 0 goes out on the rd_start edge so readout starts the very next cycle.
            relu_q      <= relu_en;
            sfu_out_q   <= relu(acc_mem_q[0], relu_en);
            sfu_valid_q <= 1'b1;
            rd_ptr_q    <= AW'(1);
            state_q     <= DRAIN;
          end else if (acc_en) begin
            state_q <= ACC;
          end
        end
        ACC: begin
          if (!acc_en) begin
            state_q <= IDLE;
          end else if (ofifo_valid) begin
            acc_mem_q[acc_ptr_q] <= acc_sum_d;
            acc_ptr_q            <= acc_ptr_q + 1'b1;
            acc_wrap_q           <= (acc_ptr_q == AW'(acc_depth - 1));
          end
        end
        DRAIN: begin
          sfu_out_q   <= relu(acc_mem_q[rd_ptr_q], relu_q);
          sfu_valid_q <= 1'b1;
          sfu_last_q  <= (rd_ptr_q == AW'(acc_depth - 1));
          rd_ptr_q    <= rd_ptr_q + 1'b1;
          if (rd_ptr_q == AW'(acc_depth - 1)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sfu_out     = sfu_out_q;
  assign sfu_o_valid = sfu_valid_q;
  assign sfu_o_last  = sfu_last_q;
  assign acc_wrap    = acc_wrap_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_corelet_acc.sv
// Scoreboard bench for corelet_acc: stimulus pushes expected readout vectors, a negedge monitor checks them.

module tb_corelet_acc;
  localparam int ROW   = 8;
  localparam int COL   = 8;
  localparam int BW    = 4;
  localparam int PW    = 16;
  localparam int DEPTH = 16;
  localparam int IBW   = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [IBW-1:0]      inst;
  logic [ROW*BW-1:0]   l0_in;
  logic                l0_o_full;
  logic                ofifo_o_full;
  logic [COL*PW-1:0]   sfu_out;
  logic                sfu_o_valid;
  logic                sfu_o_last;
  logic                acc_wrap;
  logic                busy;

  corelet_acc #(
    .row(ROW), .col(COL), .bw(BW), .psum_bw(PW), .acc_depth(DEPTH), .inst_bw(IBW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst         (inst),
    .l0_in        (l0_in),
    .l0_o_full    (l0_o_full),
    .ofifo_o_full (ofifo_o_full),
    .sfu_out      (sfu_out),
    .sfu_o_valid  (sfu_o_valid),
    .sfu_o_last   (sfu_o_last),
    .acc_wrap     (acc_wrap),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [COL*PW-1:0] data;
    logic              last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   wrap_cnt  = 0;
  int   valid_cnt = 0;
  int   w_m   [COL][ROW];
  int   ent_m [DEPTH][COL];
  int   ptr_m     = 0;
  int   exp_wraps = 0;
  logic acc_lvl   = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (acc_wrap) wrap_cnt++;
      if (sfu_o_valid) begin
        valid_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_readout: got sfu_o_valid=1 data=%h, required no readout", sfu_out);
        end else begin
          mon_e = sb_q.pop_front();
          if (sfu_out !== mon_e.data || sfu_o_last !== mon_e.last) begin
            failures++;
            $display("FAIL readout: got %h last=%b, required %h last=%b",
                     sfu_out, sfu_o_last, mon_e.data, mon_e.last);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [IBW-1:0] mk(input logic [1:0] w, input logic wr, input logic rd,
                                        input logic clr, input logic rs, input logic relu);
    logic [IBW-1:0] v;
    v      = '0;
    v[1:0] = w;
    v[2]   = wr;
    v[3]   = rd;
    v[4]   = acc_lvl;
    v[5]   = clr;
    v[6]   = relu;
    v[7]   = rs;
    return v;
  endfunction

  task automatic step(input logic [IBW-1:0] v);
    inst = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic clear_model();
    for (int e = 0; e < DEPTH; e++)
      for (int c = 0; c < COL; c++) ent_m[e][c] = 0;
    ptr_m = 0;
  endtask

  task automatic load_weights();
    logic [ROW*BW-1:0] v;
    for (int c = 0; c < COL; c++) begin
      v = '0;
      for (int r = 0; r < ROW; r++) v[r*BW +: BW] = BW'(w_m[c][r]);
      l0_in = v;
      step(mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      step(mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic push_vec(input logic [ROW*BW-1:0] acts);
    int s;
    int t;
    for (int c = 0; c < COL; c++) begin
      s = 0;
      for (int r = 0; r < ROW; r++) s += int'(acts[r*BW +: BW]) * w_m[c][r];
      t = ent_m[ptr_m][c] + s;
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
      ent_m[ptr_m][c] = t;
    end
    ptr_m = (ptr_m + 1) % DEPTH;
    if (ptr_m == 0) exp_wraps++;
    l0_in = acts;
    step(mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step(mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_expect(input logic relu);
    exp_t x;
    int   v;
    for (int e = 0; e < DEPTH; e++) begin
      x.data = '0;
      for (int c = 0; c < COL; c++) begin
        v = ent_m[e][c];
        if (relu && v < 0) v = 0;
        x.data[c*PW +: PW] = PW'(v);
      end
      x.last = (e == DEPTH - 1);
      sb_q.push_back(x);
    end
  endtask

  task automatic expect_drain(input logic relu, input int clr_at);
    push_expect(relu);
    step(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, relu));
    check("busy_in_drain", int'(busy), 1);
    for (int i = 0; i < DEPTH + 8 && sb_q.size() != 0; i++)
      step(mk(2'b00, 1'b0, 1'b0, (i == clr_at), 1'b0, 1'b0));
    check("drain_complete_remaining", sb_q.size(), 0);
    sb_q.delete();
    idle(1);
    check("busy_after_drain", int'(busy), 0);
    check("valid_after_drain", int'(sfu_o_valid), 0);
  endtask

  task automatic acc_pass(input int n, input logic [ROW*BW-1:0] acts);
    acc_lvl = 1'b1;
    idle(1);
    check("busy_in_acc", int'(busy), 1);
    repeat (n) push_vec(acts);
    idle(4);
    acc_lvl = 1'b0;
    idle(2);
  endtask

  logic [ROW*BW-1:0] acts;
  int                v0;

  initial begin
    reset = 1'b1;
    inst  = '0;
    l0_in = '0;
    for (int c = 0; c < COL; c++)
      for (int r = 0; r < ROW; r++) w_m[c][r] = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_sfu_out_nonzero", int'(sfu_out != '0), 0);
    check("reset_valid", int'(sfu_o_valid), 0);
    check("reset_last", int'(sfu_o_last), 0);
    check("reset_acc_wrap", int'(acc_wrap), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_l0_full", int'(l0_o_full), 0);
    check("reset_ofifo_full", int'(ofifo_o_full), 0);
    reset = 1'b0;
    idle(1);

    // Two passes of lane c = c+1 give 2(c+1) everywhere.
    for (int c = 0; c < COL; c++) begin
      w_m[c][0] = (c + 1 > 7) ? 7 : c + 1;
      w_m[c][1] = c + 1 - w_m[c][0];
    end
    load_weights();
    acts = '0;
    acts[0*BW +: BW] = 4'd1;
    acts[1*BW +: BW] = 4'd1;
    acc_pass(DEPTH, acts);
    check("wrap_after_pass1", wrap_cnt, exp_wraps);
    acc_pass(DEPTH, acts);
    check("wrap_after_pass2", wrap_cnt, exp_wraps);
    check("wrap_pass_total", wrap_cnt, 2);
    expect_drain(1'b0, -1);

    // Reset five vectors into a drain.
    push_expect(1'b0);
    step(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    idle(5);
    check("sb_after_5_readouts", sb_q.size(), DEPTH - 5);
    reset = 1'b1;
    sb_q.delete();
    idle(1);
    reset = 1'b0;
    check("midreset_valid", int'(sfu_o_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_out_nonzero", int'(sfu_out != '0), 0);
    for (int c = 0; c < COL; c++)
      for (int r = 0; r < ROW; r++) w_m[c][r] = 0;
    clear_model();
    exp_wraps = wrap_cnt;
    expect_drain(1'b0, -1);

    // ReLU on lanes {-5, 0, 7, ...}.
    w_m[0][0] = -5; w_m[1][0] = 0;  w_m[2][0] = 7;  w_m[3][0] = -1;
    w_m[4][0] = 3;  w_m[5][0] = -8; w_m[6][0] = 2;  w_m[7][0] = -3;
    load_weights();
    acts = '0;
    acts[0*BW +: BW] = 4'd1;
    acc_pass(DEPTH, acts);
    expect_drain(1'b1, -1);
    expect_drain(1'b0, -1);

    // acc_clr during DRAIN leaves data intact.
    expect_drain(1'b0, 2);
    expect_drain(1'b0, -1);

    // acc_clr + rd_start + acc_en in IDLE: clear only.
    acc_lvl = 1'b1;
    step(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    acc_lvl = 1'b0;
    check("priority_busy", int'(busy), 0);
    idle(2);
    check("priority_busy_later", int'(busy), 0);
    clear_model();
    expect_drain(1'b0, -1);

    // rd_start during ACC is ignored.
    v0 = valid_cnt;
    acc_lvl = 1'b1;
    idle(1);
    acts = '0;
    acts[0*BW +: BW] = 4'd1;
    push_vec(acts);
    push_vec(acts);
    step(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    check("busy_rdstart_in_acc", int'(busy), 1);
    push_vec(acts);
    push_vec(acts);
    idle(4);
    check("no_readout_in_acc", valid_cnt - v0, 0);

    // Stalled OFIFO, then acc_en drop and resume at the same pointer.
    acts[0*BW +: BW] = 4'd2;
    push_vec(acts);
    idle(2);
    acts[0*BW +: BW] = 4'd3;
    push_vec(acts);
    idle(4);
    acc_lvl = 1'b0;
    idle(2);
    acts[0*BW +: BW] = 4'd4;
    push_vec(acts);
    idle(3);
    check("busy_while_paused", int'(busy), 0);
    acc_lvl = 1'b1;
    idle(5);
    acc_lvl = 1'b0;
    idle(2);
    check("wrap_after_stall", wrap_cnt, exp_wraps);
    expect_drain(1'b0, -1);

    // Saturation: lane0 climbs past +32767, lane1 past -32768, lane2 stays linear.
    step(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    clear_model();
    for (int c = 0; c < COL; c++)
      for (int r = 0; r < ROW; r++) w_m[c][r] = 0;
    for (int r = 0; r < ROW; r++) begin
      w_m[0][r] = 7;
      w_m[1][r] = -8;
    end
    w_m[2][0] = 1;
    load_weights();
    acts = '1;
    acc_pass(DEPTH * 39, acts);
    check("wrap_after_39_passes", wrap_cnt, exp_wraps);
    expect_drain(1'b0, -1);
    acc_pass(DEPTH, acts);
    check("wrap_after_40_passes", wrap_cnt, exp_wraps);
    expect_drain(1'b0, -1);
    expect_drain(1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
